// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: scans a CPU-written hex value across multiplexed 7-segment digits.
// New values commit only at frame boundaries, or on the next cycle while the display is off.
module hex_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  lzb_en,
    input  logic                  wr_valid,
    input  logic [4*DIGITS-1:0]   wr_data,
    output logic                  wr_ready,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_done
);
    localparam int IW = $clog2(DIGITS);
    localparam int TW = $clog2(SCAN_DIV);

    typedef enum logic {OFF, SCAN} state_t;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [TW-1:0]       tick;
    logic [4*DIGITS-1:0] active;
    logic [4*DIGITS-1:0] shadow;
    logic                pending;
    logic [3:0]          nib;
    logic [6:0]          hex;
    logic [6:0]          seg_d;
    logic [DIGITS-1:0]   blank;
    logic                zeros;
    logic                tick_end;
    logic                idx_end;
    logic                accept;
    logic                commit;
    logic                pending_nx;

    always_comb begin
        nib = active[{idx, 2'b00} +: 4];
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            default: hex = 7'h0E;
        endcase
        // digit i is blank when it and every higher nibble are zero; digit 0 always shows
        blank = '0;
        zeros = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zeros = zeros && (active[4*i +: 4] == 4'h0);
            blank[i] = lzb_en && zeros;
        end
        seg_d      = blank[idx] ? 7'h7F : hex;
        tick_end   = tick == TW'(SCAN_DIV - 1);
        idx_end    = idx == IW'(DIGITS - 1);
        accept     = wr_valid && wr_ready;
        commit     = pending && (state == OFF || (tick_end && idx_end));
        pending_nx = accept || (pending && !commit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OFF;
            idx        <= '0;
            tick       <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            wr_ready   <= 1'b1;
            seg_n      <= 7'h7F;
            dig_n      <= '1;
            frame_done <= 1'b0;
        end else begin
            pending  <= pending_nx;
            wr_ready <= !pending_nx;
            if (accept)
                shadow <= wr_data;
            if (commit)
                active <= shadow;
            // raised one cycle early so the pulse lands on the frame-end cycle itself
            frame_done <= state == SCAN && en && idx_end && tick == TW'(SCAN_DIV - 2);
            if (state == OFF || !en) begin
                state <= en ? SCAN : OFF;
                idx   <= '0;
                tick  <= '0;
                seg_n <= 7'h7F;
                dig_n <= '1;
            end else begin
                tick  <= tick_end ? '0 : tick + 1'b1;
                idx   <= tick_end ? (idx_end ? '0 : idx + 1'b1) : idx;
                seg_n <= tick == '0 ? seg_d : seg_n;
                dig_n <= tick == '0 ? '1 : ~(DIGITS'(1) << idx);
            end
        end
    end
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed scenario checks of hex_scan_ctrl with DIGITS=4, SCAN_DIV=4.
module tb_hex_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        lzb_en = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic        wr_ready;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    logic        frame_done;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    hex_scan_ctrl #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .lzb_en(lzb_en), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .seg_n(seg_n), .dig_n(dig_n),
        .frame_done(frame_done)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        en = 1'b1;
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks += 4;
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset seg got %h want 7f", seg_n); end
        if (dig_n !== 4'hF) begin errors++; $display("FAIL reset dig got %h want f", dig_n); end
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset ready got %b want 1", wr_ready); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset fd got %b want 0", frame_done); end
        step;
        checks += 2;
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL reset start seg got %h want 7f", seg_n); end
        if (dig_n !== 4'hF) begin errors++; $display("FAIL reset start dig got %h want f", dig_n); end
        step;
        checks += 2;
        if (seg_n !== 7'h40) begin errors++; $display("FAIL reset dead seg got %h want 40", seg_n); end
        if (dig_n !== 4'hF) begin errors++; $display("FAIL reset dead dig got %h want f", dig_n); end
        step;
        checks += 2;
        if (seg_n !== 7'h40) begin errors++; $display("FAIL reset lit seg got %h want 40", seg_n); end
        if (dig_n !== 4'hE) begin errors++; $display("FAIL reset lit dig got %h want e", dig_n); end
    endtask

    task automatic test_scan_order;
        logic [6:0] e [4];
        logic [3:0] ed;
        e = '{7'h19, 7'h30, 7'h24, 7'h79};
        en = 1'b0;
        step;
        checks += 2;
        if (dig_n !== 4'hF) begin errors++; $display("FAIL off dig got %h want f", dig_n); end
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL off seg got %h want 7f", seg_n); end
        wr_valid = 1'b1;
        wr_data = 16'h1234;
        step;
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL off accept ready got %b want 0", wr_ready); end
        step;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL off commit ready got %b want 1", wr_ready); end
        en = 1'b1;
        step;
        for (int s = 0; s < 32; s++) begin
            step;
            ed = (s % 4 == 0) ? 4'hF : ~(4'b0001 << ((s / 4) % 4));
            checks += 3;
            if (dig_n !== ed) begin errors++; $display("FAIL scan dig s=%0d got %h want %h", s, dig_n, ed); end
            if (seg_n !== e[(s / 4) % 4]) begin errors++; $display("FAIL scan seg s=%0d got %h want %h", s, seg_n, e[(s / 4) % 4]); end
            if (frame_done !== (s % 16 == 14)) begin errors++; $display("FAIL scan fd s=%0d got %b", s, frame_done); end
        end
    endtask

    task automatic test_tear_free;
        logic [6:0] e0 [4];
        logic [6:0] e1 [4];
        logic [6:0] es;
        e0 = '{7'h19, 7'h30, 7'h24, 7'h79};
        e1 = '{7'h21, 7'h46, 7'h03, 7'h08};
        for (int s = 0; s < 32; s++) begin
            if (s == 5) begin
                wr_valid = 1'b1;
                wr_data = 16'hABCD;
            end
            step;
            wr_valid = 1'b0;
            es = s < 16 ? e0[(s / 4) % 4] : e1[(s / 4) % 4];
            checks += 2;
            if (seg_n !== es) begin errors++; $display("FAIL tear seg s=%0d got %h want %h", s, seg_n, es); end
            if (wr_ready !== !(s >= 5 && s <= 14)) begin errors++; $display("FAIL tear ready s=%0d got %b", s, wr_ready); end
        end
    endtask

    task automatic test_frame_end_write;
        logic [6:0] e0 [4];
        logic [6:0] e1 [4];
        logic [6:0] es;
        e0 = '{7'h21, 7'h46, 7'h03, 7'h08};
        e1 = '{7'h40, 7'h0E, 7'h40, 7'h40};
        for (int s = 0; s < 48; s++) begin
            if (s == 15) begin
                checks++;
                if (frame_done !== 1'b1) begin errors++; $display("FAIL fend pulse got %b want 1", frame_done); end
                wr_valid = 1'b1;
                wr_data = 16'h00F0;
            end
            step;
            wr_valid = 1'b0;
            es = s < 32 ? e0[(s / 4) % 4] : e1[(s / 4) % 4];
            checks += 2;
            if (seg_n !== es) begin errors++; $display("FAIL fend seg s=%0d got %h want %h", s, seg_n, es); end
            if (wr_ready !== !(s >= 15 && s <= 30)) begin errors++; $display("FAIL fend ready s=%0d got %b", s, wr_ready); end
        end
    endtask

    task automatic test_lzb;
        logic [6:0] e [4];
        logic [3:0] ed;
        e = '{7'h40, 7'h0E, 7'h7F, 7'h7F};
        lzb_en = 1'b1;
        for (int s = 0; s < 16; s++) begin
            step;
            ed = (s % 4 == 0) ? 4'hF : ~(4'b0001 << (s / 4));
            checks += 2;
            if (dig_n !== ed) begin errors++; $display("FAIL lzb dig s=%0d got %h want %h", s, dig_n, ed); end
            if (seg_n !== e[s / 4]) begin errors++; $display("FAIL lzb seg s=%0d got %h want %h", s, seg_n, e[s / 4]); end
        end
    endtask

    task automatic test_enable_off;
        logic [6:0] e [4];
        logic [3:0] ed;
        e = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        repeat (10) step;
        checks++;
        if (dig_n !== 4'hB) begin errors++; $display("FAIL en digit2 dig got %h want b", dig_n); end
        en = 1'b0;
        step;
        checks += 2;
        if (dig_n !== 4'hF) begin errors++; $display("FAIL en off dig got %h want f", dig_n); end
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL en off seg got %h want 7f", seg_n); end
        wr_valid = 1'b1;
        wr_data = 16'h0000;
        step;
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL en write ready got %b want 0", wr_ready); end
        step;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL en commit ready got %b want 1", wr_ready); end
        en = 1'b1;
        step;
        for (int s = 0; s < 16; s++) begin
            step;
            ed = (s % 4 == 0) ? 4'hF : ~(4'b0001 << (s / 4));
            checks += 2;
            if (dig_n !== ed) begin errors++; $display("FAIL restart dig s=%0d got %h want %h", s, dig_n, ed); end
            if (seg_n !== e[s / 4]) begin errors++; $display("FAIL restart seg s=%0d got %h want %h", s, seg_n, e[s / 4]); end
        end
    endtask

    task automatic test_reset_pending;
        lzb_en = 1'b0;
        repeat (3) step;
        wr_valid = 1'b1;
        wr_data = 16'h5555;
        step;
        wr_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL rstp pending ready got %b want 0", wr_ready); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks += 3;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstp ready got %b want 1", wr_ready); end
        if (dig_n !== 4'hF) begin errors++; $display("FAIL rstp dig got %h want f", dig_n); end
        if (seg_n !== 7'h7F) begin errors++; $display("FAIL rstp seg got %h want 7f", seg_n); end
        step;
        for (int s = 0; s < 16; s++) begin
            step;
            checks += 2;
            if (seg_n !== 7'h40) begin errors++; $display("FAIL rstp seg s=%0d got %h want 40", s, seg_n); end
            if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstp ready s=%0d got %b want 1", s, wr_ready); end
        end
    endtask

    initial begin
        test_reset;
        test_scan_order;
        test_tear_free;
        test_frame_end_write;
        test_lzb;
        test_enable_off;
        test_reset_pending;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
